// File: rtl/serial_pattern_gen_if.sv
// Request and serial-output bundle of serial_pattern_gen.
// master drives the load request, slave is the generator.
interface serial_pattern_gen_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned LW = 4,
    parameter int unsigned RW = 4,
    parameter int unsigned GW = 3
);
    logic          start;
    logic [W-1:0]  pat;
    logic [LW-1:0] len;
    logic [RW-1:0] reps;
    logic [GW-1:0] gap;
    logic          x;
    logic          x_valid;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, pat, len, reps, gap,
        input  x, x_valid, busy, done, err
    );

    modport slave (
        input  start, pat, len, reps, gap,
        output x, x_valid, busy, done, err
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: shifts pat[len-1:0] out MSB first, repeated reps times
// with gap idle cycles between repetitions. All outputs are registered.
module serial_pattern_gen #(
    parameter int unsigned W  = 8,
    parameter int unsigned LW = 4,
    parameter int unsigned RW = 4,
    parameter int unsigned GW = 3
) (
    input  logic               clk,
    input  logic               rst,
    serial_pattern_gen_if.slave bus
);
    localparam logic [LW-1:0] LenMax = LW'(W);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e        state_q;
    logic [W-1:0]  pat_q;
    logic [W-1:0]  sh_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] bits_q;
    logic [RW-1:0] reps_q;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_cnt_q;
    logic          x_q;
    logic          x_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic          len_ok;
    logic [W-1:0]  pat_aligned;

    // The active field is left-aligned so the current bit is always sh_q[W-1].
    always_comb begin
        len_ok      = (bus.len != '0) && (bus.len <= LenMax);
        pat_aligned = bus.pat << (LenMax - bus.len);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            sh_q      <= '0;
            len_q     <= '0;
            bits_q    <= '0;
            reps_q    <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    x_q       <= 1'b0;
                    x_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (bus.start) begin
                        if (len_ok) begin
                            pat_q     <= pat_aligned;
                            sh_q      <= pat_aligned;
                            len_q     <= bus.len;
                            bits_q    <= bus.len - LW'(1);
                            reps_q    <= (bus.reps == '0) ? RW'(1) : bus.reps;
                            gap_q     <= bus.gap;
                            x_q       <= pat_aligned[W-1];
                            x_valid_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= StShift;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    if (bits_q != '0) begin
                        bits_q    <= bits_q - LW'(1);
                        sh_q      <= sh_q << 1;
                        x_q       <= sh_q[W-2];
                        x_valid_q <= 1'b1;
                    end else if (reps_q > RW'(1)) begin
                        reps_q <= reps_q - RW'(1);
                        if (gap_q != '0) begin
                            gap_cnt_q <= gap_q;
                            x_q       <= 1'b0;
                            x_valid_q <= 1'b0;
                            state_q   <= StGap;
                        end else begin
                            // Back-to-back repetition: reload without a bubble.
                            bits_q    <= len_q - LW'(1);
                            sh_q      <= pat_q;
                            x_q       <= pat_q[W-1];
                            x_valid_q <= 1'b1;
                        end
                    end else begin
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GW'(1)) begin
                        bits_q    <= len_q - LW'(1);
                        sh_q      <= pat_q;
                        x_q       <= pat_q[W-1];
                        x_valid_q <= 1'b1;
                        state_q   <= StShift;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = x_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: vector table, corner sequences and
// randomized transfers against a queue-based model of the expected bit stream.
module tb_serial_pattern_gen;
    localparam int W  = 8;
    localparam int LW = 4;
    localparam int RW = 4;
    localparam int GW = 3;

    typedef struct {
        logic [W-1:0] pat;
        int           len;
        int           reps;
        int           gap;
        int           exp_bits;
        int           exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passed = 0;
    vec_t vecs[6];
    int   bad_len[3];

    always #5 clk = ~clk;

    serial_pattern_gen_if #(.W(W), .LW(LW), .RW(RW), .GW(GW)) bus ();

    serial_pattern_gen #(.W(W), .LW(LW), .RW(RW), .GW(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, x_valid, x, done, err}
    function automatic logic [4:0] outs();
        return {bus.busy, bus.x_valid, bus.x, bus.done, bus.err};
    endfunction

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act == want) passed++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, want);
    endtask

    task automatic launch(input logic [W-1:0] p, input int l, input int r, input int g);
        bus.pat   = p;
        bus.len   = LW'(l);
        bus.reps  = RW'(r);
        bus.gap   = GW'(g);
        bus.start = 1'b1;
    endtask

    // Expects start already applied; returns in the done cycle, after sampling it.
    task automatic observe(input string name, input logic [W-1:0] p, input int l, input int r,
                           input int g, input bit hold, output int vbits, output int bcycles);
        logic [1:0]   exp_q[$];
        logic [W-1:0] tmp;
        int           n;
        int           re;
        re    = (r == 0) ? 1 : r;
        exp_q = {};
        for (int k = 0; k < re; k++) begin
            for (int i = l - 1; i >= 0; i--) begin
                tmp = p >> i;
                exp_q.push_back({1'b1, tmp[0]});
            end
            if (k != re - 1) for (int j = 0; j < g; j++) exp_q.push_back(2'b00);
        end
        vbits   = 0;
        bcycles = 0;
        tick();
        if (!hold) bus.start = 1'b0;
        // Captured values must not follow the inputs mid-transfer.
        bus.pat  = W'($urandom);
        bus.len  = LW'($urandom);
        bus.reps = RW'($urandom);
        bus.gap  = GW'($urandom);
        n = exp_q.size();
        for (int i = 0; i <= n; i++) begin
            logic [4:0] want;
            if (i < n) want = {1'b1, exp_q[i], 2'b00};
            else want = 5'b00010;
            check($sformatf("%s cyc%0d", name, i), outs(), want);
            if (bus.busy) bcycles++;
            if (bus.x_valid) vbits++;
            if (i == n - 1) bus.start = 1'b0;
            if (i < n) tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int vb;
        int bc;
        vecs[0] = '{8'b00000101, 3, 1, 0, 3, 3};
        vecs[1] = '{8'b01010011, 8, 0, 0, 8, 8};
        vecs[2] = '{8'b00000101, 3, 3, 2, 9, 13};
        vecs[3] = '{8'hA5, 1, 4, 1, 4, 7};
        vecs[4] = '{8'hC3, 8, 2, 0, 16, 16};
        vecs[5] = '{8'h3C, 5, 2, 7, 10, 17};
        bad_len = '{0, 9, 15};

        bus.start = 1'b0;
        bus.pat   = '0;
        bus.len   = '0;
        bus.reps  = '0;
        bus.gap   = '0;

        // Reset must win over a legal start.
        rst = 1'b0;
        launch(8'hFF, 8, 1, 0);
        tick();
        tick();
        check("reset outputs", outs(), 0);
        rst = 1'b1;
        bus.start = 1'b0;
        tick();
        check("idle after reset", outs(), 0);

        for (int t = 0; t < 6; t++) begin
            launch(vecs[t].pat, vecs[t].len, vecs[t].reps, vecs[t].gap);
            observe($sformatf("vec%0d", t), vecs[t].pat, vecs[t].len, vecs[t].reps,
                    vecs[t].gap, 1'b0, vb, bc);
            check($sformatf("vec%0d valid bits", t), vb, vecs[t].exp_bits);
            check($sformatf("vec%0d busy cycles", t), bc, vecs[t].exp_busy);
            tick();
            check($sformatf("vec%0d done clear", t), outs(), 0);
        end

        for (int i = 0; i < 3; i++) begin
            launch(8'hFF, bad_len[i], 2, 1);
            tick();
            bus.start = 1'b0;
            check($sformatf("err len=%0d", bad_len[i]), outs(), 5'b00001);
            tick();
            check($sformatf("err clear len=%0d", bad_len[i]), outs(), 0);
        end

        // start held with a different pat during SHIFT, then a start in the done cycle.
        launch(8'hF0, 8, 1, 0);
        observe("hold", 8'hF0, 8, 1, 0, 1'b1, vb, bc);
        launch(8'h5A, 4, 2, 1);
        observe("chain", 8'h5A, 4, 2, 1, 1'b0, vb, bc);
        check("chain valid bits", vb, 8);
        tick();
        check("chain done clear", outs(), 0);

        // Reset during the second bit of a len=8 transfer.
        launch(8'hA5, 8, 1, 0);
        tick();
        bus.start = 1'b0;
        check("abort bit0", outs(), 5'b11100);
        tick();
        check("abort bit1", outs(), 5'b11000);
        rst = 1'b0;
        tick();
        check("abort reset", outs(), 0);
        rst = 1'b1;
        tick();
        check("abort no done", outs(), 0);
        launch(8'h96, 8, 1, 0);
        observe("after abort", 8'h96, 8, 1, 0, 1'b0, vb, bc);
        tick();
        check("after abort clear", outs(), 0);

        for (int t = 0; t < 25; t++) begin
            logic [W-1:0] p;
            int l;
            int r;
            int g;
            p = W'($urandom);
            l = $urandom_range(1, W);
            r = $urandom_range(0, 3);
            g = $urandom_range(0, 3);
            launch(p, l, r, g);
            observe($sformatf("rnd%0d", t), p, l, r, g, 1'b0, vb, bc);
            check($sformatf("rnd%0d busy cycles", t), bc,
                  l * ((r == 0) ? 1 : r) + g * (((r == 0) ? 1 : r) - 1));
            tick();
            check($sformatf("rnd%0d done clear", t), outs(), 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Serial bit-stream transmitter: the source end of the serial pattern link consumed by the team's pattern-detector FSMs.
- Loads a parallel pattern of programmable length and shifts it out one bit per clock, MSB of the active field first.
- Optionally repeats the pattern with a programmable idle gap between repetitions.
- Used as stimulus and source for detector blocks, and as a stand-alone serializer.

Parameters:
- W, 8, maximum pattern width in bits (W >= 2)
- LW, 4, width of len input; must hold W (2^LW > W)
- RW, 4, width of reps input
- GW, 3, width of gap input

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-low; rst==0 at a rising edge resets the block
- start  input  1  request to transmit; sampled only in IDLE
- pat  input  W  pattern; active field is pat[len-1:0]
- len  input  LW  pattern length in bits, legal 1..W
- reps  input  RW  repetition count; 0 is treated as 1
- gap  input  GW  idle cycles inserted between repetitions (not after the last)
- x  output  1  serial data bit, registered
- x_valid  output  1  x carries a pattern bit this cycle, registered
- busy  output  1  transfer in progress, registered
- done  output  1  one-cycle pulse at end of transfer, registered
- err  output  1  one-cycle pulse when start is rejected for illegal len, registered

Behaviour:
- Reset: state=IDLE; x=0, x_valid=0, busy=0, done=0, err=0; internal shift register, bit counter, rep counter and gap counter cleared. Reset wins over every other event, including start in the same cycle.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - start=1 with 1<=len<=W: capture pat, len, max(reps,1) and gap.
  - At that same edge: go to SHIFT, drive x=pat[len-1], x_valid=1, busy=1. Latency from start sampled to first bit is 1 cycle.
  - start=1 with len==0 or len>W: stay in IDLE; err=1 for exactly one cycle; busy and x_valid stay 0.
  - start=0: hold, with x=0 and x_valid=0.
- SHIFT:
  - Each edge presents the next lower bit: pat[len-1], pat[len-2], ..., pat[0].
  - Each bit is held for exactly one cycle with x_valid=1.
  - After bit pat[0], if repetitions remain and gap>0: next edge enters GAP with x=0, x_valid=0.
  - If repetitions remain and gap==0: next edge restarts at pat[len-1] with no bubble; x_valid stays 1.
  - After bit pat[0] of the last repetition: next edge goes to IDLE with x=0, x_valid=0, busy=0, done=1.
- GAP: stays exactly gap cycles with x=0, x_valid=0, busy=1, then enters SHIFT at pat[len-1].
- done and err are high for one cycle only; both deassert on the following edge.
- start while busy=1 is ignored with no side effects. Captured values are not affected by input changes mid-transfer.
- start may be accepted in the cycle done=1 (state is IDLE). The new transfer's first bit then follows with no extra gap.
- Total valid bits per transfer = len * max(reps,1). Total busy cycles = that + gap*(max(reps,1)-1).
- Reset mid-transfer: abort immediately; the next cycle shows x_valid=0 and busy=0; done is not pulsed.
- len==1: every repetition is a single bit pat[0].

Test Plan:
- pat=8'b00000101, len=3, reps=1, gap=0, start pulse at cycle 0 -> x/x_valid = 1/1, 0/1, 1/1 on cycles 1-3. Cycle 4: x_valid=0, busy=0, done=1. Cycle 5: done=0.
- pat=8'b01010011, len=8, reps=0 -> x sequence 0,1,0,1,0,0,1,1 on 8 consecutive cycles with x_valid=1, then done. Stream fed to the "101" detector yields its expected outputs.
- pat=3'b101, len=3, reps=3, gap=2 -> x_valid pattern 1,1,1,0,0,1,1,1,0,0,1,1,1 with data 1,0,1,-,-,1,0,1,-,-,1,0,1. busy high 13 cycles; done on cycle 14.
- len=0 then len=9 (W=8), each with start -> err=1 for one cycle each; busy, x_valid and done stay 0.
- start re-asserted with a different pat during SHIFT -> ignored, output unchanged. A new start in the done cycle -> next transfer begins the following cycle.
- rst=0 at the second bit of a len=8 transfer -> next cycle x=0, x_valid=0, busy=0, done=0. A subsequent start operates normally.
